// File: rtl/uart_line_monitor_if.sv
// Line output bus of the UART line monitor: a completed line plus its
// valid/ready handshake. The monitor drives the master side, the consumer
// (checker) drives the slave side.
interface uart_line_monitor_if #(
    parameter int MAX_LINE_LEN = 132
);
    localparam int LEN_W = $clog2(MAX_LINE_LEN + 1);

    logic                      line_valid;
    logic                      line_ready;
    logic [MAX_LINE_LEN*8-1:0] line_data;
    logic [LEN_W-1:0]          line_len;
    logic                      line_truncated;

    modport master (
        output line_valid,
        output line_data,
        output line_len,
        output line_truncated,
        input  line_ready
    );

    modport slave (
        input  line_valid,
        input  line_data,
        input  line_len,
        input  line_truncated,
        output line_ready
    );
endinterface

// File: rtl/uart_line_monitor.sv
// UART line monitor: oversampled receiver with parity/stop/break checking
// that assembles received characters into lines and offers each completed
// line on a valid/ready bus so bench checkers can consume console output.
// Optional macro UART_LINE_MONITOR_LOG_EN prints every committed line.

`ifdef UART_LINE_MONITOR_LOG_EN
`ifndef logI
`define logI(msg) $display("%s", msg)
`endif
`endif

module uart_line_monitor #(
    parameter int         BIT_RATE     = 9600,
    parameter int         CLK_HZ       = 50_000_000,
    parameter int         PAYLOAD_BITS = 8,
    parameter int         PARITY_MODE  = 0,
    parameter int         STOP_BITS    = 1,
    parameter int         MAX_LINE_LEN = 132,
    parameter logic [7:0] EOL_CHAR     = 8'h0A,
    parameter bit         DROP_CR      = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                uart_rxd,
    input  logic                uart_rx_en,
    output logic                rx_byte_valid,
    output logic [7:0]          rx_byte,
    output logic                parity_err,
    output logic                frame_err,
    output logic                break_det,
    uart_line_monitor_if.master line_if,
    output logic [15:0]         lines_dropped
);
    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
    localparam int LEN_W          = $clog2(MAX_LINE_LEN + 1);
    localparam int DATA_W         = MAX_LINE_LEN * 8;

    localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_BIT   = CNT_W'(CYCLES_PER_BIT / 2);
    localparam logic [LEN_W-1:0] FULL_LEN   = LEN_W'(MAX_LINE_LEN);
    localparam logic [2:0]       LAST_DATA  = 3'(PAYLOAD_BITS - 1);
    localparam logic [2:0]       LAST_STOP  = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rxState_t;

    logic sync1_q, sync2_q, prev_q;

    rxState_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitCnt_q, bitCnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             parityBit_q, parityBit_d;
    logic             stopErr_q, stopErr_d;
    logic             firstStopLow_q, firstStopLow_d;

    logic       rxValid_q, rxValid_d;
    logic [7:0] rxByte_q, rxByte_d;
    logic       perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;

    logic [DATA_W-1:0] lineBuf_q, lineBuf_d;
    logic [LEN_W-1:0]  idx_q, idx_d;

    logic              lineValid_q, lineValid_d;
    logic [DATA_W-1:0] lineData_q, lineData_d;
    logic [LEN_W-1:0]  lineLen_q, lineLen_d;
    logic              lineTrunc_q, lineTrunc_d;
    logic [15:0]       dropped_q, dropped_d;

    logic              tick, expectedParity;
    logic              commit, commitTrunc, accept, outFree;
    logic [DATA_W-1:0] commitData;
    logic [LEN_W-1:0]  commitLen;

    // Two-flop synchroniser plus one history flop for falling-edge detection; idle-high after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign tick           = (cnt_q == '0);
    assign expectedParity = (PARITY_MODE == 1) ? ~^shift_q : ^shift_q;

    // Receiver next-state: mid-bit sampling driven by a down-counter, result pulsed one cycle after the last stop sample
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bitCnt_d       = bitCnt_q;
        shift_d        = shift_q;
        parityBit_d    = parityBit_q;
        stopErr_d      = stopErr_q;
        firstStopLow_d = firstStopLow_q;
        rxValid_d      = 1'b0;
        rxByte_d       = 8'h00;
        perr_d         = 1'b0;
        ferr_d         = 1'b0;
        brk_d          = 1'b0;
        case (state_q)
            IDLE: begin
                if (uart_rx_en && prev_q && !sync2_q) begin
                    state_d = START;
                    cnt_d   = HALF_BIT;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!sync2_q) begin
                    state_d        = DATA;
                    cnt_d          = BIT_RELOAD;
                    bitCnt_d       = 3'd0;
                    shift_d        = 8'h00;
                    stopErr_d      = 1'b0;
                    firstStopLow_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d[bitCnt_q] = sync2_q;
                    cnt_d             = BIT_RELOAD;
                    if (bitCnt_q == LAST_DATA) begin
                        bitCnt_d = 3'd0;
                        state_d  = (PARITY_MODE != 0) ? PARITY : STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    parityBit_d = sync2_q;
                    cnt_d       = BIT_RELOAD;
                    bitCnt_d    = 3'd0;
                    state_d     = STOP;
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (bitCnt_q == LAST_STOP) begin
                    state_d   = IDLE;
                    rxValid_d = 1'b1;
                    rxByte_d  = shift_q;
                    ferr_d    = stopErr_q | ~sync2_q;
                    perr_d    = (PARITY_MODE != 0) && (parityBit_q != expectedParity);
                    brk_d     = (shift_q == 8'h00) &&
                                ((bitCnt_q == 3'd0) ? ~sync2_q : firstStopLow_q);
                end else begin
                    stopErr_d      = stopErr_q | ~sync2_q;
                    firstStopLow_d = (bitCnt_q == 3'd0) ? ~sync2_q : firstStopLow_q;
                    bitCnt_d       = bitCnt_q + 3'd1;
                    cnt_d          = BIT_RELOAD;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!uart_rx_en && state_q != IDLE) begin
            state_d   = IDLE;
            rxValid_d = 1'b0;
            rxByte_d  = 8'h00;
            perr_d    = 1'b0;
            ferr_d    = 1'b0;
            brk_d     = 1'b0;
        end
    end

    // Receiver state and the registered per-frame result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            bitCnt_q       <= 3'd0;
            shift_q        <= 8'h00;
            parityBit_q    <= 1'b0;
            stopErr_q      <= 1'b0;
            firstStopLow_q <= 1'b0;
            rxValid_q      <= 1'b0;
            rxByte_q       <= 8'h00;
            perr_q         <= 1'b0;
            ferr_q         <= 1'b0;
            brk_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bitCnt_q       <= bitCnt_d;
            shift_q        <= shift_d;
            parityBit_q    <= parityBit_d;
            stopErr_q      <= stopErr_d;
            firstStopLow_q <= firstStopLow_d;
            rxValid_q      <= rxValid_d;
            rxByte_q       <= rxByte_d;
            perr_q         <= perr_d;
            ferr_q         <= ferr_d;
            brk_q          <= brk_d;
        end
    end

    assign accept  = lineValid_q && line_if.line_ready;
    assign outFree = !lineValid_q || accept;

    // Line assembly and output register: clean bytes are buffered, EOL or overflow commits, a busy output drops the line
    always_comb begin
        lineBuf_d   = lineBuf_q;
        idx_d       = idx_q;
        commit      = 1'b0;
        commitData  = '0;
        commitLen   = '0;
        commitTrunc = 1'b0;
        lineValid_d = lineValid_q;
        lineData_d  = lineData_q;
        lineLen_d   = lineLen_q;
        lineTrunc_d = lineTrunc_q;
        dropped_d   = dropped_q;
        if (rxValid_q && !perr_q && !ferr_q && !brk_q &&
            !(DROP_CR && rxByte_q == 8'h0D)) begin
            if (rxByte_q == EOL_CHAR) begin
                commit     = 1'b1;
                commitData = lineBuf_q;
                commitLen  = idx_q;
                lineBuf_d  = '0;
                idx_d      = '0;
            end else if (idx_q == FULL_LEN) begin
                commit          = 1'b1;
                commitData      = lineBuf_q;
                commitLen       = idx_q;
                commitTrunc     = 1'b1;
                lineBuf_d       = '0;
                lineBuf_d[7:0]  = rxByte_q;
                idx_d           = LEN_W'(1);
            end else begin
                lineBuf_d[{idx_q, 3'b000} +: 8] = rxByte_q;
                idx_d                           = idx_q + LEN_W'(1);
            end
        end
        if (accept) begin
            lineValid_d = 1'b0;
        end
        if (commit) begin
            if (outFree) begin
                lineValid_d = 1'b1;
                lineData_d  = commitData;
                lineLen_d   = commitLen;
                lineTrunc_d = commitTrunc;
            end else if (dropped_q != 16'hFFFF) begin
                dropped_d = dropped_q + 16'd1;
            end
        end
    end

    // Assembly buffer, held output line and the dropped-line counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lineBuf_q   <= '0;
            idx_q       <= '0;
            lineValid_q <= 1'b0;
            lineData_q  <= '0;
            lineLen_q   <= '0;
            lineTrunc_q <= 1'b0;
            dropped_q   <= 16'h0000;
        end else begin
            lineBuf_q   <= lineBuf_d;
            idx_q       <= idx_d;
            lineValid_q <= lineValid_d;
            lineData_q  <= lineData_d;
            lineLen_q   <= lineLen_d;
            lineTrunc_q <= lineTrunc_d;
            dropped_q   <= dropped_d;
        end
    end

`ifdef UART_LINE_MONITOR_LOG_EN
    // Simulation-only console echo of each committed or dropped line
    always @(posedge clk) begin
        string s;
        if (!reset && commit) begin
            s = outFree ? "TB_UART: " : "DROPPED TB_UART: ";
            for (int i = 0; i < MAX_LINE_LEN; i++) begin
                if (i < int'(commitLen)) s = $sformatf("%s%c", s, commitData[i*8 +: 8]);
            end
            if (commitTrunc) s = {s, " [TRUNC]"};
            `logI(s);
        end
    end
`endif

    assign rx_byte_valid          = rxValid_q;
    assign rx_byte                = rxByte_q;
    assign parity_err             = perr_q;
    assign frame_err              = ferr_q;
    assign break_det              = brk_q;
    assign line_if.line_valid     = lineValid_q;
    assign line_if.line_data      = lineData_q;
    assign line_if.line_len       = lineLen_q;
    assign line_if.line_truncated = lineTrunc_q;
    assign lines_dropped          = dropped_q;
endmodule

// File: tb/tb_uart_line_monitor.sv
// Directed bench for uart_line_monitor: 10 cycles per bit, even parity,
// one stop bit, four-character lines so truncation is easy to reach.
module tb_uart_line_monitor;
    localparam int CPB    = 10;
    localparam int MAXLEN = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        rxd;
    logic        rxEn;
    logic        rxValid;
    logic [7:0]  rxByte;
    logic        perr, ferr, brk;
    logic [15:0] dropped;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
        int         cyc;
    } byteRec_t;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  len;
        logic        trunc;
        int          cyc;
    } lineRec_t;

    byteRec_t byteQ[$];
    lineRec_t lineQ[$];
    logic     validPrev = 1'b0;

    uart_line_monitor_if #(.MAX_LINE_LEN(MAXLEN)) lineIf ();

    uart_line_monitor #(
        .BIT_RATE    (5_000_000),
        .CLK_HZ      (50_000_000),
        .PAYLOAD_BITS(8),
        .PARITY_MODE (2),
        .STOP_BITS   (1),
        .MAX_LINE_LEN(MAXLEN),
        .EOL_CHAR    (8'h0A),
        .DROP_CR     (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rxd     (rxd),
        .uart_rx_en   (rxEn),
        .rx_byte_valid(rxValid),
        .rx_byte      (rxByte),
        .parity_err   (perr),
        .frame_err    (ferr),
        .break_det    (brk),
        .line_if      (lineIf.master),
        .lines_dropped(dropped)
    );

    // Free-running bench clock and cycle stamp
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every received-byte pulse and every rising line_valid on the falling edge
    always @(negedge clk) begin
        if (rxValid) byteQ.push_back('{rxByte, perr, ferr, brk, cyc});
        if (lineIf.line_valid && !validPrev)
            lineQ.push_back('{lineIf.line_data, lineIf.line_len, lineIf.line_truncated, cyc});
        validPrev = lineIf.line_valid;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One even-parity frame, optionally with the parity bit inverted, followed by one idle bit
    task automatic applyStimulus(input logic [7:0] ch, input logic flipPar);
        logic par;
        par = (^ch) ^ flipPar;
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = ch[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = par;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic sendText(input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b0);
    endtask

    task automatic clearLogs();
        byteQ.delete();
        lineQ.delete();
    endtask

    initial begin
        reset = 1'b1;
        rxd   = 1'b1;
        rxEn  = 1'b1;
        lineIf.line_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_rx_valid", 64'(rxValid), 64'd0);
        checkOutput("reset_line_valid", 64'(lineIf.line_valid), 64'd0);
        checkOutput("reset_line_len", 64'(lineIf.line_len), 64'd0);
        checkOutput("reset_dropped", 64'(dropped), 64'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] basic line OK<CR><LF>");
        clearLogs();
        sendText("OK");
        applyStimulus(8'h0D, 1'b0);
        applyStimulus(8'h0A, 1'b0);
        checkOutput("basic_pulses", 64'(byteQ.size()), 64'd4);
        checkOutput("basic_cr_byte", 64'(byteQ[2].data), 64'h0D);
        checkOutput("basic_lines", 64'(lineQ.size()), 64'd1);
        checkOutput("basic_data", 64'(lineQ[0].data), 64'h0000_4B4F);
        checkOutput("basic_len", 64'(lineQ[0].len), 64'd2);
        checkOutput("basic_trunc", 64'(lineQ[0].trunc), 64'd0);
        checkOutput("basic_latency", 64'(lineQ[0].cyc - byteQ[3].cyc), 64'd1);

        $display("[TB] parity error then clean A<LF>");
        clearLogs();
        applyStimulus(8'h41, 1'b1);
        checkOutput("par_pulses", 64'(byteQ.size()), 64'd1);
        checkOutput("par_err", 64'(byteQ[0].perr), 64'd1);
        checkOutput("par_frame_err", 64'(byteQ[0].ferr), 64'd0);
        checkOutput("par_byte", 64'(byteQ[0].data), 64'h41);
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h0A, 1'b0);
        checkOutput("par_clean_err", 64'(byteQ[1].perr), 64'd0);
        checkOutput("par_lines", 64'(lineQ.size()), 64'd1);
        checkOutput("par_line_len", 64'(lineQ[0].len), 64'd1);
        checkOutput("par_line_data", 64'(lineQ[0].data), 64'h0000_0041);

        $display("[TB] break, false start and enable abort");
        clearLogs();
        rxd = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checkOutput("brk_pulses", 64'(byteQ.size()), 64'd1);
        checkOutput("brk_flag", 64'(byteQ[0].brk), 64'd1);
        checkOutput("brk_frame_err", 64'(byteQ[0].ferr), 64'd1);
        checkOutput("brk_byte", 64'(byteQ[0].data), 64'h00);
        checkOutput("brk_no_line", 64'(lineQ.size()), 64'd0);
        clearLogs();
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checkOutput("glitch_no_pulse", 64'(byteQ.size()), 64'd0);
        rxd = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        rxEn = 1'b0;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (8 * CPB) @(negedge clk);
        rxEn = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checkOutput("abort_no_pulse", 64'(byteQ.size()), 64'd0);

        $display("[TB] truncation ABCDEF<LF>");
        clearLogs();
        sendText("ABCDEF");
        applyStimulus(8'h0A, 1'b0);
        checkOutput("trunc_lines", 64'(lineQ.size()), 64'd2);
        checkOutput("trunc1_data", 64'(lineQ[0].data), 64'h4443_4241);
        checkOutput("trunc1_len", 64'(lineQ[0].len), 64'd4);
        checkOutput("trunc1_flag", 64'(lineQ[0].trunc), 64'd1);
        checkOutput("trunc1_latency", 64'(lineQ[0].cyc - byteQ[4].cyc), 64'd1);
        checkOutput("trunc2_data", 64'(lineQ[1].data), 64'h0000_4645);
        checkOutput("trunc2_len", 64'(lineQ[1].len), 64'd2);
        checkOutput("trunc2_flag", 64'(lineQ[1].trunc), 64'd0);

        $display("[TB] backpressure a b c");
        clearLogs();
        lineIf.line_ready = 1'b0;
        sendText("a");
        applyStimulus(8'h0A, 1'b0);
        sendText("b");
        applyStimulus(8'h0A, 1'b0);
        sendText("c");
        applyStimulus(8'h0A, 1'b0);
        checkOutput("bp_lines", 64'(lineQ.size()), 64'd1);
        checkOutput("bp_held_valid", 64'(lineIf.line_valid), 64'd1);
        checkOutput("bp_held_data", 64'(lineIf.line_data), 64'h0000_0061);
        checkOutput("bp_held_len", 64'(lineIf.line_len), 64'd1);
        checkOutput("bp_dropped", 64'(dropped), 64'd2);
        lineIf.line_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_valid_falls", 64'(lineIf.line_valid), 64'd0);
        checkOutput("bp_dropped_kept", 64'(dropped), 64'd2);

        $display("[TB] reset mid-frame and mid-line");
        lineIf.line_ready = 1'b0;
        sendText("q");
        applyStimulus(8'h0A, 1'b0);
        sendText("r");
        checkOutput("rst_pre_valid", 64'(lineIf.line_valid), 64'd1);
        rxd = 1'b0;
        repeat (25) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_rx_valid", 64'(rxValid), 64'd0);
        checkOutput("rst_rx_byte", 64'(rxByte), 64'd0);
        checkOutput("rst_flags", 64'({perr, ferr, brk}), 64'd0);
        checkOutput("rst_line_valid", 64'(lineIf.line_valid), 64'd0);
        checkOutput("rst_line_data", 64'(lineIf.line_data), 64'd0);
        checkOutput("rst_line_len", 64'(lineIf.line_len), 64'd0);
        checkOutput("rst_line_trunc", 64'(lineIf.line_truncated), 64'd0);
        checkOutput("rst_dropped", 64'(dropped), 64'd0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        lineIf.line_ready = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        clearLogs();
        sendText("x");
        applyStimulus(8'h0A, 1'b0);
        checkOutput("post_rst_lines", 64'(lineQ.size()), 64'd1);
        checkOutput("post_rst_len", 64'(lineQ[0].len), 64'd1);
        checkOutput("post_rst_data", 64'(lineQ[0].data), 64'h0000_0078);
        checkOutput("post_rst_trunc", 64'(lineQ[0].trunc), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_line_monitor.md
Name: uart_line_monitor

Overview:
- Parametrised testbench UART line monitor for the CEP co-simulation bench.
- Contains its own oversampled receiver with configurable parity and stop bits, plus error detection.
- Assembles received bytes into lines and presents each completed line on a valid/ready handshake, so checkers can consume console output instead of only logging it.

Parameters:
- BIT_RATE, 9600, serial bit rate in bits/s.
- CLK_HZ, 50_000_000, clk frequency; CYCLES_PER_BIT = CLK_HZ/BIT_RATE, integer division, must be >= 4.
- PAYLOAD_BITS, 8, data bits per frame (5..8); unused upper bits of rx_byte are 0.
- PARITY_MODE, 0, parity: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame (1 or 2).
- MAX_LINE_LEN, 132, maximum characters held per line.
- EOL_CHAR, 8'h0A, line terminator character.
- DROP_CR, 1, when 1, byte 8'h0D is discarded and never stored.

Ports:
- clk  input  1  bench clock.
- reset  input  1  asynchronous, active-high reset.
- uart_rxd  input  1  serial input, idle high.
- uart_rx_en  input  1  receiver enable.
- rx_byte_valid  output  1  one-cycle pulse per received frame.
- rx_byte  output  8  received payload, LSB first on the wire.
- parity_err  output  1  qualifies rx_byte_valid: parity mismatch.
- frame_err  output  1  qualifies rx_byte_valid: a stop bit was sampled low.
- break_det  output  1  qualifies rx_byte_valid: all data bits 0 and first stop bit 0.
- line_valid  output  1  a completed line is held in the output register.
- line_ready  input  1  consumer accepts the line.
- line_data  output  MAX_LINE_LEN*8  line characters; char i sits at [i*8 +: 8]; unused bytes are 0.
- line_len  output  $clog2(MAX_LINE_LEN+1)  number of valid characters.
- line_truncated  output  1  line hit MAX_LINE_LEN without a terminator.
- lines_dropped  output  16  saturating count of lines lost to backpressure.

Behaviour:
- Reset, asynchronous:
  - All outputs are 0.
  - Synchroniser flops are 1.
  - Assembly buffer, index and output register are cleared.
  - FSM goes to IDLE.
  - A frame or line in progress is discarded.
- Input path: uart_rxd passes through a 2-flop synchroniser; all decisions use the synchronised value.
- RX FSM states and transitions:
  - IDLE: on a synchronised falling edge with uart_rx_en=1, go to START and load the counter with CYCLES_PER_BIT/2.
  - START: sample at counter expiry. Low: go to DATA. High: false start, return to IDLE with no pulse.
  - DATA: sample PAYLOAD_BITS bits, one every CYCLES_PER_BIT.
  - PARITY: present only if PARITY_MODE != 0; one bit sampled.
  - STOP: STOP_BITS samples. Any low sample sets frame_err. The FSM returns to IDLE after the last stop sample.
- rx_byte_valid pulses exactly 1 cycle after the last stop sample. rx_byte and the error flags are valid in that cycle only.
- Dropping uart_rx_en mid-frame aborts the frame: return to IDLE, no pulse.
- Line assembly uses each rx_byte_valid byte.
- Discarded, counting nothing:
  - bytes with any error flag set;
  - 8'h0D when DROP_CR=1.
- EOL_CHAR:
  - is not stored;
  - commits the buffer with line_truncated=0;
  - an empty line (len 0) is committed.
- Any other byte:
  - buffer not full: store at the current index, index+1;
  - buffer full (index == MAX_LINE_LEN): first commit the full buffer with line_truncated=1, then store the byte at index 0 of a fresh line, index = 1.
- Commit:
  - If the output register is free, or line_valid && line_ready in the same cycle, load line_data/line_len/line_truncated and set line_valid=1 next cycle.
  - Otherwise the line is dropped and lines_dropped increments, saturating at 16'hFFFF.
  - The assembly buffer is cleared in both cases.
- Handshake:
  - line_valid stays high and line_* stay stable until line_valid && line_ready.
  - line_valid falls the next cycle unless a simultaneous commit reloads the register.
- Latency: the terminator's rx_byte_valid cycle to line_valid high is 1 cycle.

Optional Feature:
- Macro: UART_LINE_MONITOR_LOG_EN.
- Defined: on every commit, print through `logI as "TB_UART: <line_len chars>". Truncated lines are printed with suffix " [TRUNC]"; dropped lines are printed with prefix "DROPPED ".
- Undefined: no simulation output; the RTL is otherwise identical.

Test Plan:
- Common config: CLK_HZ=50_000_000, BIT_RATE=5_000_000 (10 cycles/bit), line_ready=1.
- Basic line: drive "OK\r\n" -> 4 rx_byte_valid pulses; one line with line_len=2, line_data[15:0]=16'h4B4F, line_truncated=0; line_valid 1 cycle after the 0x0A pulse.
- Parity: PARITY_MODE=2; send 0x41 with the parity bit flipped -> rx_byte_valid with parity_err=1; byte absent from the line. A subsequent "A\n" gives line_len=1, data 0x41.
- Break and false start:
  - hold rxd low for 12 bit times -> pulse with break_det=1 and frame_err=1;
  - a low glitch of 3 cycles -> no pulse.
- Truncation: MAX_LINE_LEN=4; send "ABCDEF\n" -> line "ABCD" with truncated=1, then line "EF" with len=2, truncated=0.
- Backpressure: line_ready=0; send "a\nb\nc\n" -> line "a" held stable; lines_dropped=2. Raise line_ready -> line_valid falls next cycle.
- Reset: assert reset mid-frame and mid-line -> all outputs 0 immediately; the next clean "x\n" yields len=1 with no leftover characters.
